// File: rtl/peripheral_wb_burst_master.sv
// peripheral_wb_burst_master: Wishbone B3 master that turns single-word
// commands into classic or incrementing-burst bus cycles. Write beats are
// staged in a FIFO first so stb_o stays high for the whole burst.
module peripheral_wb_burst_master #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned LW        = $clog2(MAX_BURST)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [31:0]   cmd_adr,
    input  logic [LW-1:0] cmd_len,
    input  logic [1:0]    cmd_bte,
    input  logic [3:0]    cmd_sel,
    input  logic [31:0]   wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [31:0]   rd_data,
    output logic          rd_valid,
    output logic          done_valid,
    output logic          done_err,
    output logic [31:0]   adr_o,
    output logic [31:0]   dat_o,
    output logic [3:0]    sel_o,
    output logic          we_o,
    output logic [1:0]    bte_o,
    output logic [2:0]    cti_o,
    output logic          cyc_o,
    output logic          stb_o,
    input  logic [31:0]   dat_i,
    input  logic          ack_i,
    input  logic          err_i
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_BUS, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [29:0]   idx_q, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic [1:0]    bte_q, bte_d;
    logic [3:0]    sel_q, sel_d;
    logic [LW:0]   beat_q, beat_d;
    logic [LW:0]   fill_q, fill_d;
    logic          err_q, err_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [31:0]   fifo_q [MAX_BURST];

    logic          push;
    logic [LW:0]   len_ext;
    logic          in_bus;
    logic          last_beat;
    logic          fill_open;
    logic [29:0]   idx_inc;
    logic [29:0]   idx_next;
    logic          unused_adr;

    assign len_ext    = {1'b0, len_q};
    assign in_bus     = (state_q == S_BUS);
    assign last_beat  = (beat_q == len_ext);
    assign fill_open  = (state_q == S_FILL) && (fill_q <= len_ext);
    assign push       = fill_open && wr_valid;
    assign unused_adr = ^cmd_adr[1:0];

    // Next word index: linear increment or modulo increment inside the wrap window
    always_comb begin
        idx_inc = idx_q + 30'd1;
        case (bte_q)
            2'd1:    idx_next = {idx_q[29:2], idx_inc[1:0]};
            2'd2:    idx_next = {idx_q[29:3], idx_inc[2:0]};
            2'd3:    idx_next = {idx_q[29:4], idx_inc[3:0]};
            default: idx_next = idx_inc;
        endcase
    end

    // Command FSM: latch command, fill write FIFO, run bus cycle, report completion
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        idx_d      = idx_q;
        len_d      = len_q;
        bte_d      = bte_q;
        sel_d      = sel_q;
        beat_d     = beat_q;
        fill_d     = fill_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    idx_d   = cmd_adr[31:2];
                    len_d   = cmd_len;
                    bte_d   = cmd_bte;
                    sel_d   = cmd_sel;
                    beat_d  = '0;
                    fill_d  = '0;
                    err_d   = 1'b0;
                    state_d = cmd_we ? S_FILL : S_BUS;
                end
            end
            S_FILL: begin
                if (push) begin
                    fill_d = fill_q + (LW+1)'(1);
                    if (fill_q == len_ext) begin
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // err_i wins over a simultaneous ack_i; unsent FIFO beats are discarded
                if (err_i) begin
                    err_d   = 1'b1;
                    fill_d  = '0;
                    state_d = S_DONE;
                end else if (ack_i) begin
                    if (!we_q) begin
                        rd_data_d  = dat_i;
                        rd_valid_d = 1'b1;
                    end
                    idx_d = idx_next;
                    if (last_beat) begin
                        fill_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + (LW+1)'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            idx_q      <= '0;
            len_q      <= '0;
            bte_q      <= '0;
            sel_q      <= '0;
            beat_q     <= '0;
            fill_q     <= '0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            bte_q      <= bte_d;
            sel_q      <= sel_d;
            beat_q     <= beat_d;
            fill_q     <= fill_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Write FIFO storage; pushes fill from slot 0, bus beats read slot beat_q
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[fill_q[LW-1:0]] <= wr_data;
        end
    end

    // Cycle type: classic for single beats, incrementing burst with end-of-burst on the last
    always_comb begin
        cti_o = 3'b000;
        if (in_bus && (len_q != '0)) begin
            cti_o = last_beat ? 3'b111 : 3'b010;
        end
    end

    assign cmd_ready  = rst && (state_q == S_IDLE);
    assign wr_ready   = fill_open;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign done_valid = (state_q == S_DONE);
    assign done_err   = (state_q == S_DONE) && err_q;
    assign cyc_o      = in_bus;
    assign stb_o      = in_bus;
    assign we_o       = in_bus && we_q;
    assign adr_o      = in_bus ? {idx_q, 2'b00} : '0;
    assign sel_o      = in_bus ? sel_q : '0;
    assign bte_o      = (in_bus && (len_q != '0)) ? bte_q : '0;
    assign dat_o      = (in_bus && we_q) ? fifo_q[beat_q[LW-1:0]] : '0;

endmodule

// File: tb/tb_peripheral_wb_burst_master.sv
// tb_peripheral_wb_burst_master: directed bench with a zero-wait-state
// Wishbone memory slave and optional error injection on the third beat.
module tb_peripheral_wb_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_len;
    logic [1:0]  cmd_bte;
    logic [3:0]  cmd_sel;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done_valid;
    logic        done_err;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic [1:0]  bte_o;
    logic [2:0]  cti_o;
    logic        cyc_o;
    logic        stb_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    int n_checks = 0;
    int n_fail   = 0;

    peripheral_wb_burst_master #(.MAX_BURST(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_bte(cmd_bte), .cmd_sel(cmd_sel),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .done_valid(done_valid), .done_err(done_err),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
        .bte_o(bte_o), .cti_o(cti_o), .cyc_o(cyc_o), .stb_o(stb_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    always #5 clk = ~clk;

    // Memory slave: 256 words, acks every strobed cycle unless an error is injected
    logic [31:0] mem [256];
    logic        mem_loaded = 1'b0;
    logic        err_en = 1'b0;
    int          bus_beats = 0;

    assign err_i = err_en && cyc_o && stb_o && (bus_beats == 2);
    assign ack_i = cyc_o && stb_o && !err_i;
    assign dat_i = mem[adr_o[9:2]];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000 + 32'(i);
            mem[4]     <= 32'hA5A5_0001;
            mem_loaded <= 1'b1;
        end else if (cyc_o && stb_o && we_o && ack_i) begin
            for (int b = 0; b < 4; b++)
                if (sel_o[b]) mem[adr_o[9:2]][8*b +: 8] <= dat_o[8*b +: 8];
        end
        if (!cyc_o) bus_beats <= 0;
        else if (ack_i) bus_beats <= bus_beats + 1;
    end

    // Bus / read / completion logs, sampled on the falling edge
    logic [31:0] log_adr [256];
    logic [2:0]  log_cti [256];
    logic [1:0]  log_bte [256];
    logic [31:0] rd_log  [256];
    int          log_n = 0;
    int          rd_n  = 0;

    always @(negedge clk) begin
        if (cyc_o && stb_o && (ack_i || err_i)) begin
            log_adr[log_n] <= adr_o;
            log_cti[log_n] <= cti_o;
            log_bte[log_n] <= bte_o;
            log_n          <= log_n + 1;
        end
        if (rd_valid) begin
            rd_log[rd_n] <= rd_data;
            rd_n         <= rd_n + 1;
        end
    end

    logic [31:0] wdata [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present a command at a falling edge and hold it until accepted
    task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] len,
                         input logic [1:0] bte, input logic [3:0] sel);
        int g;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr;
        cmd_len = len; cmd_bte = bte; cmd_sel = sel;
        g = 0;
        while (!cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check1("cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Push n beats from wdata[]; one extra offered beat must be refused
    task automatic push(input int n);
        int  i;
        int  g;
        logic ok;
        i = 0; g = 0;
        while (i < n && g < 100) begin
            wr_valid = 1'b1;
            wr_data  = wdata[i];
            ok = wr_ready;
            @(negedge clk);
            if (ok) i++;
            g++;
        end
        check("push_count", 32'(i), 32'(n));
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output logic err_out);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (done_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check1({tag, "_done"}, got, 1'b1);
        check1({tag, "_cyc_at_done"}, cyc_o, 1'b0);
        err_out = done_err;
        @(negedge clk);
        check1({tag, "_done_one_cycle"}, done_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lb;
        int   rb;
        logic e;

        rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0;
        cmd_len = '0; cmd_bte = '0; cmd_sel = '0; wr_data = '0; wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check1("rst_cyc", cyc_o, 1'b0);
        check1("rst_cmd_ready", cmd_ready, 1'b0);
        check1("rst_wr_ready", wr_ready, 1'b0);
        check1("rst_done_valid", done_valid, 1'b0);
        check1("rst_rd_valid", rd_valid, 1'b0);
        check("rst_adr", adr_o, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check1("post_rst_cmd_ready", cmd_ready, 1'b1);

        // Single-beat read; nonzero bte must not appear on a single beat
        lb = log_n; rb = rd_n;
        issue(1'b0, 32'h10, 4'd0, 2'd2, 4'hF);
        check1("rd1_latency_cyc", cyc_o, 1'b1);
        check1("rd1_stb", stb_o, 1'b1);
        check1("rd1_cmd_ready_busy", cmd_ready, 1'b0);
        wait_done("rd1", e);
        check1("rd1_err", e, 1'b0);
        check("rd1_beats", 32'(log_n - lb), 32'd1);
        check("rd1_cti", 32'(log_cti[lb]), 32'd0);
        check("rd1_bte", 32'(log_bte[lb]), 32'd0);
        check("rd1_adr", log_adr[lb], 32'h10);
        check("rd1_nvalid", 32'(rd_n - rb), 32'd1);
        check("rd1_data", rd_log[rb], 32'hA5A5_0001);

        // 4-beat linear write then read-back
        for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
        lb = log_n;
        issue(1'b1, 32'h20, 4'd3, 2'd0, 4'hF);
        push(4);
        wr_valid = 1'b1;
        check1("w4_extra_refused", wr_ready, 1'b0);
        wr_valid = 1'b0;
        wait_done("w4", e);
        check1("w4_err", e, 1'b0);
        check("w4_beats", 32'(log_n - lb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w4_adr%0d", i), log_adr[lb + i], 32'h20 + 32'(4 * i));
            check($sformatf("w4_cti%0d", i), 32'(log_cti[lb + i]), (i == 3) ? 32'd7 : 32'd2);
        end
        rb = rd_n;
        issue(1'b0, 32'h20, 4'd3, 2'd0, 4'hF);
        wait_done("r4", e);
        check("r4_nvalid", 32'(rd_n - rb), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("r4_data%0d", i), rd_log[rb + i], 32'(i + 1));

        // Wrap4 read from 0x38
        lb = log_n; rb = rd_n;
        issue(1'b0, 32'h38, 4'd3, 2'd1, 4'hF);
        wait_done("wrap4", e);
        check("wrap4_adr0", log_adr[lb + 0], 32'h38);
        check("wrap4_adr1", log_adr[lb + 1], 32'h3C);
        check("wrap4_adr2", log_adr[lb + 2], 32'h30);
        check("wrap4_adr3", log_adr[lb + 3], 32'h34);
        for (int i = 0; i < 4; i++)
            check($sformatf("wrap4_bte%0d", i), 32'(log_bte[lb + i]), 32'd1);
        check("wrap4_data0", rd_log[rb + 0], 32'h0000_100E);
        check("wrap4_data2", rd_log[rb + 2], 32'h0000_100C);

        // Partial byte-select write over a known word
        wdata[0] = 32'h1234_5678;
        lb = log_n;
        issue(1'b1, 32'h100, 4'd0, 2'd0, 4'hF);
        push(1);
        wait_done("wfull", e);
        check("wfull_cti", 32'(log_cti[lb]), 32'd0);
        wdata[0] = 32'hFFFF_FFFF;
        issue(1'b1, 32'h100, 4'd0, 2'd0, 4'b0011);
        push(1);
        wait_done("wpart", e);
        rb = rd_n;
        issue(1'b0, 32'h100, 4'd0, 2'd0, 4'hF);
        wait_done("rpart", e);
        check("rpart_data", rd_log[rb], 32'h1234_FFFF);

        // Linear burst across the top of the address space
        lb = log_n; rb = rd_n;
        issue(1'b0, 32'hFFFF_FFFC, 4'd1, 2'd0, 4'hF);
        wait_done("top", e);
        check("top_adr0", log_adr[lb], 32'hFFFF_FFFC);
        check("top_adr1", log_adr[lb + 1], 32'h0);
        check("top_data1", rd_log[rb + 1], 32'h0000_1000);

        // Error on beat 3 of an 8-beat read
        err_en = 1'b1;
        rb = rd_n;
        issue(1'b0, 32'h0, 4'd7, 2'd0, 4'hF);
        wait_done("err_rd", e);
        check1("err_rd_done_err", e, 1'b1);
        check("err_rd_nvalid", 32'(rd_n - rb), 32'd2);
        // Error on beat 3 of a 4-beat write; leftover beats must not leak
        for (int i = 0; i < 4; i++) wdata[i] = 32'hAA00_0000 + 32'(i);
        issue(1'b1, 32'h180, 4'd3, 2'd0, 4'hF);
        push(4);
        wait_done("err_wr", e);
        check1("err_wr_done_err", e, 1'b1);
        err_en = 1'b0;
        wdata[0] = 32'hCAFE_0000;
        issue(1'b1, 32'h140, 4'd0, 2'd0, 4'hF);
        push(1);
        wait_done("after_err_wr", e);
        check1("after_err_wr_err", e, 1'b0);
        rb = rd_n;
        issue(1'b0, 32'h140, 4'd0, 2'd0, 4'hF);
        wait_done("after_err_rd", e);
        check1("after_err_rd_err", e, 1'b0);
        check("after_err_rd_data", rd_log[rb], 32'hCAFE_0000);

        // Asynchronous reset in the middle of a 16-beat write burst
        for (int i = 0; i < 16; i++) wdata[i] = 32'h500 + 32'(i);
        issue(1'b1, 32'h200, 4'd15, 2'd0, 4'hF);
        push(16);
        repeat (3) @(negedge clk);
        check1("mid_burst_cyc", cyc_o, 1'b1);
        #2 rst = 1'b0;
        #1;
        check1("arst_cyc", cyc_o, 1'b0);
        check1("arst_stb", stb_o, 1'b0);
        check1("arst_we", we_o, 1'b0);
        check1("arst_wr_ready", wr_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check1("rel1_cmd_ready", cmd_ready, 1'b1);

        // Asynchronous reset while filling the write FIFO
        issue(1'b1, 32'h200, 4'd15, 2'd0, 4'hF);
        push(2);
        check1("mid_fill_wr_ready", wr_ready, 1'b1);
        #2 rst = 1'b0;
        #1;
        check1("arst_fill_wr_ready", wr_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        rb = rd_n;
        issue(1'b0, 32'h10, 4'd0, 2'd0, 4'hF);
        wait_done("post_rst_rd", e);
        check1("post_rst_rd_err", e, 1'b0);
        check("post_rst_rd_nvalid", 32'(rd_n - rb), 32'd1);
        check("post_rst_rd_data", rd_log[rb], 32'hA5A5_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_wb_burst_master.md
Name: peripheral_wb_burst_master

Overview:
Wishbone B3 master that turns single-word commands into classic or incremental-burst bus cycles toward a peripheral memory slave. Commands come from a local command port. Write beats are first buffered in an internal FIFO so that stb never drops mid-burst. Read beats stream out on a data port, and each command ends with a completion pulse carrying error status. It is the bench/application stage directly upstream of the Wishbone memory peripheral.

Parameters:
MAX_BURST, 16, maximum beats per command; power of two, 2..16; sets write FIFO depth.
LW, $clog2(MAX_BURST), width of cmd_len.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-low.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when valid&ready.
cmd_we  in  1  1=write, 0=read.
cmd_adr  in  32  start byte address; bits [1:0] ignored.
cmd_len  in  LW  beats minus one.
cmd_bte  in  2  0 linear, 1 wrap4, 2 wrap8, 3 wrap16.
cmd_sel  in  4  byte lanes, applied to every beat.
wr_data  in  32  write beat.
wr_valid  in  1  write beat present.
wr_ready  out  1  write beat accepted when valid&ready.
rd_data  out  32  read beat.
rd_valid  out  1  one-cycle qualifier; no backpressure.
done_valid  out  1  one-cycle completion pulse.
done_err  out  1  valid with done_valid; 1 if the command was aborted by err_i.
adr_o  out  32  Wishbone address, word aligned.
dat_o  out  32  Wishbone write data.
sel_o  out  4  Wishbone byte select.
we_o  out  1  Wishbone write enable.
bte_o  out  2  Wishbone burst type extension.
cti_o  out  3  Wishbone cycle type identifier.
cyc_o  out  1  Wishbone cycle.
stb_o  out  1  Wishbone strobe.
dat_i  in  32  Wishbone read data.
ack_i  in  1  Wishbone acknowledge.
err_i  in  1  Wishbone error.

Behaviour:
- Reset (rst low, asynchronous, may arrive mid-burst):
  - State goes to IDLE, FIFO is emptied, beat counter is cleared.
  - All outputs are 0, except cmd_ready=1 once out of reset.
- States:
  - IDLE: cmd_ready=1. On accept, latch cmd_*. Read goes to BUS; write goes to FILL.
  - FILL: wr_ready=1 until cmd_len+1 beats are pushed, then go to BUS on the next edge. Extra wr_valid is ignored (wr_ready=0).
  - BUS: cyc_o=stb_o=1 from the first cycle in BUS. Each sampled ack_i completes one beat.
  - DONE: done_valid=1 for exactly one cycle, then IDLE.
- Latency: read command accepted at edge N gives cyc/stb high in cycle N+1.
- cti_o rules:
  - Single beat (cmd_len=0): 3'b000.
  - Multi-beat: 3'b010 on all beats but the last; 3'b111 on the last. cti_o updates on the same edge ack is sampled.
- bte_o: equals the latched cmd_bte on multi-beat commands; 0 on single-beat commands.
- Address:
  - adr_o[1:0]=0.
  - On each ack the word index advances by 1. Linear: full 30-bit increment, wraps at 2^32. Wrap4/8/16: only index bits [1:0]/[2:0]/[3:0] increment modulo, upper bits held.
  - bte>0 with cmd_len+1 larger than the wrap size keeps wrapping; this is legal.
- Write data: dat_o = FIFO head; the FIFO pops on each ack. we_o = latched cmd_we for the whole cycle. sel_o = latched cmd_sel.
- Read data: rd_data is registered from dat_i on each ack; rd_valid pulses the cycle after that ack.
- End of transfer: on the ack of the last beat, cyc_o/stb_o/we_o are cleared at that same edge. State goes to DONE with done_err=0.
- Error: err_i sampled high (even together with ack_i) aborts the transfer.
  - No rd_valid for that beat; cyc/stb drop at that edge.
  - Remaining FIFO contents are flushed.
  - DONE with done_err=1.
- ack_i/err_i sampled while cyc_o=0 are ignored.
- Throughput: supports an ack every cycle. stb_o never deasserts between beats of one command.
- Beat counter width: LW+1 bits; the comparison to cmd_len must not overflow at MAX_BURST beats.

Test Plan:
- Read, single beat, adr=0x10, len=0, against the memory slave preloaded with 0xA5A5_0001 at word 4: cti_o=000, one ack, rd_data=0xA5A5_0001, done_valid, done_err=0.
- Write, 4-beat linear, adr=0x20, data 1..4, sel=F: cti sequence 010,010,010,111, adr_o 0x20,0x24,0x28,0x2C. Read-back of the same 4 words returns 1..4.
- Wrap4, adr=0x38, len=3 read: adr_o sequence 0x38,0x3C,0x30,0x34, bte_o=1 throughout.
- Write with partial sel=4'b0011, data 0xFFFF_FFFF, to a word holding 0x1234_5678: read-back returns 0x1234_FFFF.
- Error: 8-beat read with err_i forced on beat 3: exactly 2 rd_valid pulses, cyc_o low the next cycle, done_err=1, next command accepted normally.
- Reset asserted mid-16-beat write: cyc_o/stb_o/wr_ready go to 0 immediately without a clock edge. After release, a new 1-beat read completes correctly.
